// File: rtl/approx_mult_engine.sv
// Leading-one approximate multiplier: fetches operand pairs, normalises, multiplies truncated tops, rescales.
// Define APX_COMP_EN to OR the discarded low bits into each truncated operand's LSB.
module approx_mult_engine #(
  parameter int DATA_W  = 16,
  parameter int TRUNC_W = 8,
  parameter int N_PAIRS = 8,
  parameter int ADDR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_W-1:0]     in_addr,
  input  logic [DATA_W-1:0]     in_rdata,
  output logic [ADDR_W-1:0]     out_addr,
  output logic [2*DATA_W-1:0]   out_wdata,
  output logic                  out_we,
  output logic                  busy,
  output logic                  done
);

  localparam int SMAX  = DATA_W - TRUNC_W;
  localparam int SA_W  = (SMAX == 0) ? 1 : $clog2(SMAX + 1);
  localparam int CNT_W = (SMAX == 0) ? 1 : $clog2(2 * SMAX + 1);
  localparam int I_W   = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
  localparam int P_W   = 2 * DATA_W;
  localparam int M_W   = 2 * TRUNC_W;

  localparam logic [I_W-1:0]  I_LAST   = I_W'(N_PAIRS - 1);
  localparam logic [I_W-1:0]  I_ONE    = I_W'(1);
  localparam logic [SA_W-1:0] SA_MAX   = SA_W'(SMAX);
  localparam logic [SA_W-1:0] SA_ONE   = SA_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_LD_B,
    S_NORM_A,
    S_NORM_B,
    S_MULT,
    S_SHIFT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [I_W-1:0]      r_i;
  logic [SA_W-1:0]     r_sa;
  logic [SA_W-1:0]     r_sb;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [P_W-1:0]      r_p;
  logic [ADDR_W-1:0]   r_in_addr;
  logic [ADDR_W-1:0]   r_out_addr;
  logic [P_W-1:0]      r_out_wdata;
  logic                r_out_we;
  logic                r_busy;
  logic                r_done;

  logic [TRUNC_W-1:0]  w_a_top;
  logic [TRUNC_W-1:0]  w_b_top;
  logic [M_W-1:0]      w_prod;
  logic [P_W-1:0]      w_p_mult;

  generate
    if (SMAX > 0) begin : g_trunc
`ifdef APX_COMP_EN
      // Sticky bit: any nonzero discarded bit nudges the truncated operand up.
      assign w_a_top = r_a[DATA_W-1 -: TRUNC_W] | TRUNC_W'(|r_a[SMAX-1:0]);
      assign w_b_top = r_b[DATA_W-1 -: TRUNC_W] | TRUNC_W'(|r_b[SMAX-1:0]);
`else
      assign w_a_top = r_a[DATA_W-1 -: TRUNC_W];
      assign w_b_top = r_b[DATA_W-1 -: TRUNC_W];
`endif
    end else begin : g_exact
      assign w_a_top = r_a;
      assign w_b_top = r_b;
    end
  endgenerate

  assign w_prod   = M_W'(w_a_top) * M_W'(w_b_top);
  assign w_p_mult = P_W'(w_prod) << (2 * SMAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_i         <= '0;
      r_sa        <= '0;
      r_sb        <= '0;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_p         <= '0;
      r_in_addr   <= '0;
      r_out_addr  <= '0;
      r_out_wdata <= '0;
      r_out_we    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_out_we <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_i       <= '0;
            r_in_addr <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_RD_A;
          end
        end
        S_RD_A: begin
          r_in_addr <= r_in_addr + ADDR_W'(1);
          r_state   <= S_RD_B;
        end
        S_RD_B: begin
          r_a     <= in_rdata;
          r_sa    <= '0;
          r_state <= S_LD_B;
        end
        S_LD_B: begin
          r_b     <= in_rdata;
          r_sb    <= '0;
          r_state <= S_NORM_A;
        end
        S_NORM_A: begin
          if (r_a[DATA_W-1] || (r_sa == SA_MAX)) begin
            r_state <= S_NORM_B;
          end else begin
            r_a  <= r_a << 1;
            r_sa <= r_sa + SA_ONE;
          end
        end
        S_NORM_B: begin
          if (r_b[DATA_W-1] || (r_sb == SA_MAX)) begin
            r_state <= S_MULT;
          end else begin
            r_b  <= r_b << 1;
            r_sb <= r_sb + SA_ONE;
          end
        end
        S_MULT: begin
          r_p     <= w_p_mult;
          r_cnt   <= CNT_W'(r_sa) + CNT_W'(r_sb);
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          // Outputs are loaded on the way into WRITE so they are valid for that cycle.
          if (r_cnt == '0) begin
            r_out_we    <= 1'b1;
            r_out_addr  <= ADDR_W'(r_i);
            r_out_wdata <= r_p;
            r_state     <= S_WRITE;
          end else begin
            r_p   <= r_p >> 1;
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        S_WRITE: begin
          if (r_i == I_LAST) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_i       <= r_i + I_ONE;
            r_in_addr <= ADDR_W'({r_i + I_ONE, 1'b0});
            r_state   <= S_RD_A;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_addr   = r_in_addr;
  assign out_addr  = r_out_addr;
  assign out_wdata = r_out_wdata;
  assign out_we    = r_out_we;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
